stepper_trace_packer: RTL and testbench

STEPPER_TRACE_PACKER -- requirements
Module: stepper_trace_packer

---
 rtl/stepper_trace_pkg.sv | 18 +
 rtl/stepper_trace_packer.sv | 149 ++++++++++++++
 tb/tb_stepper_trace_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_trace_pkg.sv
// Shared parameters and output-register encoding for the stepper trace packer.
package stepper_trace_pkg;

  localparam int SYM_W_DEF = 2;
  localparam int SYMS_DEF  = 15;

  // Packed word width for a given symbol width and symbol count.
  function automatic int word_width(input int sym_w, input int syms);
    return sym_w * syms;
  endfunction

  localparam int WORD_W_DEF = word_width(SYM_W_DEF, SYMS_DEF);

  // Output register occupancy.
  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_HOLD  = 1'b1;

endpackage

// File: rtl/stepper_trace_packer.sv
// Packs a stream of small trace symbols LSB-first into fixed-width words.
// An accumulator collects symbols; a one-entry output register presents
// finished words to the consumer. Flush emits a partial word.
//
// out_state | meaning
// ----------+--------------------------------------------
// EMPTY     | output register free, word_valid low
// HOLD      | output register holds a word, word_valid high
module stepper_trace_packer
  import stepper_trace_pkg::*;
#(
  parameter  int SYM_W  = SYM_W_DEF,
  parameter  int SYMS   = SYMS_DEF,
  localparam int WORD_W = word_width(SYM_W, SYMS),
  localparam int CNT_W  = $clog2(SYMS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym_data,
  output logic              sym_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(SYMS);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              pend_q, pend_d;
  logic [0:0]        out_state_q, out_state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              out_free;
  logic              flush_eff;
  logic [CNT_W-1:0]  fill_inc;
  logic [WORD_W-1:0] sym_ext;
  logic [WORD_W-1:0] sym_ins;
  logic [WORD_W-1:0] merged;
  logic              load;
  logic [WORD_W-1:0] load_word;
  logic [CNT_W-1:0]  load_cnt;

  // Handshake: stall only when a full accumulator cannot drain this cycle.
  always_comb begin
    out_free  = (out_state_q == OUT_EMPTY) || word_ready;
    sym_ready = !((fill_q == FULL) && (out_state_q == OUT_HOLD) && !word_ready);
    accept    = sym_valid && sym_ready;
    flush_eff = flush || pend_q;
    fill_inc  = fill_q + CNT_W'(accept);
    sym_ext   = WORD_W'(sym_data);
    sym_ins   = sym_ext << (int'(fill_q) * SYM_W);
    merged    = acc_q | (accept ? sym_ins : '0);
  end

  // Next-state: accumulate, transfer to the output register, track flush.
  always_comb begin
    acc_d       = acc_q;
    fill_d      = fill_q;
    pend_d      = pend_q;
    out_state_d = out_state_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    load_word   = '0;
    load_cnt    = '0;

    if (fill_q == FULL) begin
      // A full word left over from an earlier stall; the symbol taken this
      // cycle starts the next word. A flush raised now applies to that new
      // symbol, the full word goes out regardless.
      if (out_free) begin
        load      = 1'b1;
        load_word = acc_q;
        load_cnt  = FULL;
        acc_d     = accept ? sym_ext : '0;
        fill_d    = CNT_W'(accept);
        pend_d    = flush && accept;
      end
    end else if ((fill_inc == FULL) || (flush_eff && (fill_inc != '0))) begin
      if (out_free) begin
        load      = 1'b1;
        load_word = merged;
        load_cnt  = fill_inc;
        acc_d     = '0;
        fill_d    = '0;
        pend_d    = 1'b0;
      end else begin
        // Output busy: keep the word here and remember a partial flush.
        acc_d  = merged;
        fill_d = fill_inc;
        pend_d = flush_eff && (fill_inc != FULL);
      end
    end else begin
      acc_d  = merged;
      fill_d = fill_inc;
      pend_d = 1'b0;
    end

    if (load) begin
      out_state_d = OUT_HOLD;
      word_d      = load_word;
      cnt_d       = load_cnt;
    end else if (word_ready) begin
      out_state_d = OUT_EMPTY;
    end

    // Dropping a symbol outranks a simultaneous clear.
    ovf_d = (sym_valid && !sym_ready) || (ovf_q && !ovf_clr);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      fill_q      <= '0;
      pend_q      <= 1'b0;
      out_state_q <= OUT_EMPTY;
      word_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      pend_q      <= pend_d;
      out_state_q <= out_state_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    dct_buffer = word_q;
    dct_count  = cnt_q;
    word_valid = (out_state_q == OUT_HOLD);
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_stepper_trace_packer.sv
// Self-checking bench for stepper_trace_packer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_stepper_trace_packer;

  localparam int SYM_W  = 2;
  localparam int SYMS   = 15;
  localparam int WORD_W = SYM_W * SYMS;

  logic              clk = 1'b0;
  logic              reset;
  logic              sym_valid;
  logic [SYM_W-1:0]  sym_data;
  logic              sym_ready;
  logic              flush;
  logic [WORD_W-1:0] dct_buffer;
  logic [3:0]        dct_count;
  logic              word_valid;
  logic              word_ready;
  logic              overflow;
  logic              ovf_clr;

  int checks   = 0;
  int failures = 0;

  stepper_trace_packer #(.SYM_W(SYM_W), .SYMS(SYMS)) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_ready  (sym_ready),
    .flush      (flush),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference packing: symbol k weighs 4**k.
  function automatic logic [WORD_W-1:0] pack_ref(input int unsigned s[$]);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < s.size(); k++) w = w + WORD_W'(s[k] * (4 ** k));
    return w;
  endfunction

  // Drive one cycle of inputs; return 1 ns after the active edge.
  task automatic tick(input logic sv, input logic [SYM_W-1:0] sd, input logic fl,
                      input logic wr, input logic clr);
    sym_valid = sv; sym_data = sd; flush = fl; word_ready = wr; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sym_valid = 1'b0; sym_data = '0; flush = 1'b0;
    word_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    checks++; if (dct_buffer !== '0) begin failures++; $display("FAIL reset_buffer got=%h exp=0", dct_buffer); end
    checks++; if (dct_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dct_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    #3 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (sym_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", sym_ready); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%b exp=0", word_valid); end
  endtask

  task automatic test_full_word();
    int unsigned s[$];
    logic [WORD_W-1:0] exp_w;
    for (int i = 0; i < SYMS; i++) begin
      s.push_back(i % 4);
      tick(1'b1, SYM_W'(i % 4), 1'b0, 1'b1, 1'b0);
      if (i < SYMS - 1) begin
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid sym=%0d got=%b exp=0", i, word_valid); end
      end
    end
    exp_w = pack_ref(s);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", word_valid); end
    checks++; if (dct_count !== 4'd15) begin failures++; $display("FAIL full_count got=%0d exp=15", dct_count); end
    checks++; if (dct_buffer !== exp_w) begin failures++; $display("FAIL full_buffer got=%h exp=%h", dct_buffer, exp_w); end
    for (int k = 0; k < SYMS; k++) begin
      checks++;
      if (dct_buffer[SYM_W*k +: SYM_W] !== SYM_W'(k % 4)) begin
        failures++; $display("FAIL full_sym k=%0d got=%0d exp=%0d", k, dct_buffer[SYM_W*k +: SYM_W], k % 4);
      end
    end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL full_drain got=%b exp=0", word_valid); end
  endtask

  task automatic test_flush_partial();
    tick(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL partial_early got=%b exp=0", word_valid); end
    tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL partial_valid got=%b exp=1", word_valid); end
    checks++; if (dct_count !== 4'd3) begin failures++; $display("FAIL partial_count got=%0d exp=3", dct_count); end
    checks++; if (dct_buffer !== 30'h0000001B) begin failures++; $display("FAIL partial_buffer got=%h exp=0000001b", dct_buffer); end
    checks++; if (dct_buffer[WORD_W-1:6] !== '0) begin failures++; $display("FAIL partial_upper got=%h exp=0", dct_buffer[WORD_W-1:6]); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_edges();
    tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", word_valid); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_late got=%b exp=0", word_valid); end
    tick(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL flush_same_valid got=%b exp=1", word_valid); end
    checks++; if (dct_count !== 4'd1) begin failures++; $display("FAIL flush_same_count got=%0d exp=1", dct_count); end
    checks++; if (dct_buffer !== 30'd2) begin failures++; $display("FAIL flush_same_buffer got=%h exp=2", dct_buffer); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int unsigned s[$];
    int unsigned first[$];
    int unsigned second[$];
    logic [WORD_W-1:0] w1, w2;
    for (int i = 0; i < 31; i++) s.push_back($urandom_range(0, 3));
    for (int i = 0; i < SYMS; i++) first.push_back(s[i]);
    for (int i = SYMS; i < 2 * SYMS; i++) second.push_back(s[i]);
    w1 = pack_ref(first);
    w2 = pack_ref(second);
    for (int i = 0; i < 2 * SYMS; i++) begin
      tick(1'b1, SYM_W'(s[i]), 1'b0, 1'b0, 1'b0);
      if (i >= SYMS - 1) begin
        checks++;
        if (word_valid !== 1'b1 || dct_buffer !== w1 || dct_count !== 4'd15) begin
          failures++; $display("FAIL bp_hold i=%0d got=%b/%h/%0d exp=1/%h/15", i, word_valid, dct_buffer, dct_count, w1);
        end
      end
    end
    checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", sym_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_ovf_pre got=%b exp=0", overflow); end
    tick(1'b1, SYM_W'(s[30]), 1'b0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf_set got=%b exp=1", overflow); end
    tick(1'b1, SYM_W'(s[30]), 1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_set_wins got=%b exp=1", overflow); end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_ovf_clr got=%b exp=0", overflow); end
    checks++; if (dct_buffer !== w1) begin failures++; $display("FAIL bp_still_held got=%h exp=%h", dct_buffer, w1); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL bp_nobubble got=%b exp=1", word_valid); end
    checks++; if (dct_buffer !== w2) begin failures++; $display("FAIL bp_second got=%h exp=%h", dct_buffer, w2); end
    checks++; if (dct_count !== 4'd15) begin failures++; $display("FAIL bp_second_count got=%0d exp=15", dct_count); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", word_valid); end
  endtask

  task automatic test_reset_mid();
    int unsigned s[$];
    logic [WORD_W-1:0] exp_w;
    for (int i = 0; i < SYMS + 7; i++) tick(1'b1, SYM_W'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL rmid_held got=%b exp=1", word_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (word_valid !== 1'b0 || dct_buffer !== '0 || dct_count !== 4'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL rmid_async got=%b/%h/%0d/%b exp=0/0/0/0", word_valid, dct_buffer, dct_count, overflow);
    end
    sym_valid = 1'b0; word_ready = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_word cyc=%0d got=%b exp=0", i, word_valid); end
    end
    s.push_back($urandom_range(0, 3));
    s.push_back($urandom_range(0, 3));
    tick(1'b1, SYM_W'(s[0]), 1'b0, 1'b1, 1'b0);
    tick(1'b1, SYM_W'(s[1]), 1'b0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    exp_w = pack_ref(s);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL rmid_valid got=%b exp=1", word_valid); end
    checks++; if (dct_count !== 4'd2) begin failures++; $display("FAIL rmid_count got=%0d exp=2", dct_count); end
    checks++; if (dct_buffer !== exp_w) begin failures++; $display("FAIL rmid_buffer got=%h exp=%h", dct_buffer, exp_w); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int unsigned m_acc[$];
    bit m_mv, m_pend, m_ovf, m_ready, acc_sym, ovf_set, free, emitted, fe;
    logic [WORD_W-1:0] m_word;
    int m_cnt;
    logic sv, fl, wr, clr;
    logic [SYM_W-1:0] sd;
    int rand_fail;
    reset = 1'b1; sym_valid = 1'b0; flush = 1'b0; word_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_mv = 0; m_pend = 0; m_ovf = 0; m_word = '0; m_cnt = 0;
    rand_fail = failures;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      sv  = ($urandom_range(0, 9) < 7);
      sd  = SYM_W'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 11) == 0);
      wr  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 19) == 0);
      sym_valid = sv; sym_data = sd; flush = fl; word_ready = wr; ovf_clr = clr;
      #1;
      m_ready = !((m_acc.size() == SYMS) && m_mv && !wr);
      checks++; if (sym_ready !== m_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, sym_ready, m_ready); end
      acc_sym = sv && m_ready;
      ovf_set = sv && !m_ready;
      free    = !m_mv || wr;
      emitted = 0;
      if (m_acc.size() == SYMS) begin
        if (free) begin
          m_word = pack_ref(m_acc); m_cnt = SYMS; emitted = 1;
          m_acc.delete();
          if (acc_sym) m_acc.push_back(sd);
          m_pend = fl && acc_sym;
        end
      end else begin
        if (acc_sym) m_acc.push_back(sd);
        fe = fl || m_pend;
        if ((m_acc.size() == SYMS) || (fe && m_acc.size() > 0)) begin
          if (free) begin
            m_word = pack_ref(m_acc); m_cnt = m_acc.size(); emitted = 1;
            m_acc.delete();
            m_pend = 0;
          end else begin
            m_pend = fe && (m_acc.size() < SYMS);
          end
        end else begin
          m_pend = 0;
        end
      end
      if (emitted) m_mv = 1; else if (wr) m_mv = 0;
      m_ovf = ovf_set || (m_ovf && !clr);
      @(posedge clk); #1;
      checks++; if (word_valid !== m_mv) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, word_valid, m_mv); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf); end
      if (m_mv) begin
        checks++;
        if (dct_buffer !== m_word || dct_count !== 4'(m_cnt)) begin
          failures++; $display("FAIL rnd_word cyc=%0d got=%h/%0d exp=%h/%0d", cyc, dct_buffer, dct_count, m_word, m_cnt);
        end
      end
      if (failures - rand_fail > 10) break;
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_edges();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
